gigatron_video_capture: RTL

GIGATRON_VIDEO_CAPTURE -- requirements
Module: gigatron_video_capture

---
 rtl/gigatron_video_capture.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/gigatron_video_capture.sv
// Captures Gigatron OUT-port video: locks to vsync/hsync, decimates lines,
// and queues {row, column, colour} entries through a 4-deep FIFO to a sink.
module gigatron_video_capture #(
    parameter int unsigned H_START  = 12,
    parameter int unsigned H_PIXELS = 160,
    parameter int unsigned V_START  = 33,
    parameter int unsigned V_LINES  = 480,
    parameter int unsigned V_DIV    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] out,
    input  logic       enable,
    input  logic       ovf_clr,
    input  logic       pix_ready,
    output logic       pix_valid,
    output logic [5:0] pix_data,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic       frame_start,
    output logic       locked,
    output logic       overflow
);

    localparam int unsigned HCNT_W     = 8;
    localparam int unsigned VCNT_W     = 10;
    localparam int unsigned COL_W      = 6;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned DIV_SH     = $clog2(V_DIV);

    localparam logic [HCNT_W-1:0] H_FIRST    = HCNT_W'(H_START);
    localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_START + H_PIXELS - 1);
    localparam logic [VCNT_W-1:0] V_FIRST    = VCNT_W'(V_START);
    localparam logic [VCNT_W-1:0] V_END      = VCNT_W'(V_START + V_LINES);
    localparam logic [VCNT_W-1:0] V_DIV_MASK = VCNT_W'(V_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    typedef struct packed {
        logic [Y_W-1:0]   y;
        logic [X_W-1:0]   x;
        logic [COL_W-1:0] colour;
    } pix_entry_t;

    state_t              state;
    state_t              next_state;
    logic [7:0]          out_q;
    logic [HCNT_W-1:0]   hcnt;
    logic [VCNT_W-1:0]   vcnt;
    logic [VCNT_W-1:0]   vcnt_inc;
    logic [VCNT_W-1:0]   rel_line;
    logic                hs_rise;
    logic                vs_rise;

    pix_entry_t          fifo_mem [FIFO_DEPTH];
    pix_entry_t          push_entry;
    pix_entry_t          head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_n;
    logic                push;
    logic                pop;
    logic                accept;
    logic                drop;

    assign hs_rise  = out[6] & ~out_q[6];
    assign vs_rise  = out[7] & ~out_q[7];
    assign vcnt_inc = vcnt + VCNT_W'(1);
    assign rel_line = vcnt - V_FIRST;

    // Sync edge detection and raster counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= 8'hC0;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            out_q <= out;
            if (hs_rise) begin
                hcnt <= '0;
            end else if (hcnt != '1) begin
                hcnt <= hcnt + HCNT_W'(1);
            end
            if (vs_rise) begin
                vcnt <= '0;
            end else if (hs_rise) begin
                vcnt <= vcnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= next_state;
            locked      <= (next_state != SEARCH);
            frame_start <= vs_rise & enable;
        end
    end

    // Next state, capture decision and FIFO handshake
    always_comb begin
        next_state = state;
        push       = 1'b0;
        push_entry = '0;
        pop        = pix_valid & pix_ready;
        accept     = 1'b0;
        drop       = 1'b0;
        count_n    = count;

        if (!enable) begin
            next_state = SEARCH;
        end else if (vs_rise) begin
            next_state = VBLANK;
        end else if (hs_rise) begin
            if (vcnt == '1) begin
                next_state = SEARCH;
            end else if (state == VBLANK && vcnt_inc == V_FIRST) begin
                next_state = ACTIVE;
            end else if (state == ACTIVE && vcnt_inc == V_END) begin
                next_state = VBLANK;
            end
        end

        if (state == ACTIVE && (rel_line & V_DIV_MASK) == '0
                && hcnt >= H_FIRST && hcnt <= H_LAST) begin
            push = 1'b1;
        end
        push_entry.y      = Y_W'(rel_line >> DIV_SH);
        push_entry.x      = X_W'(hcnt - H_FIRST);
        push_entry.colour = out_q[5:0];

        // A full FIFO still takes a push when the head leaves in the same cycle
        accept  = push & ((count != CNT_FULL) | pop);
        drop    = push & ~accept;
        count_n = count + CNT_W'(accept) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pix_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= push_entry;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_n;
            pix_valid <= (count_n != '0);
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head     = fifo_mem[rd_ptr];
    assign pix_data = head.colour;
    assign pix_x    = head.x;
    assign pix_y    = head.y;

endmodule
